// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin front end that shares one sequential multiplier among NREQ clients.
// Define MUL_ARB_TIMEOUT_EN to compile in a watchdog that aborts a job stuck waiting for mul_done.
module mul_arbiter #(
  parameter int N       = 32,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 48
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*N-1:0]   req_a,
  input  logic [NREQ*N-1:0]   req_b,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     resp_valid,
  output logic [2*N-1:0]      resp_product,
  output logic                resp_err,
  output logic                mul_start,
  output logic [N-1:0]        mul_multiplicand,
  output logic [N-1:0]        mul_multiplier,
  input  logic [2*N-1:0]      mul_product,
  input  logic                mul_busy,
  input  logic                mul_done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_winner;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_resp_valid;
  logic [2*N-1:0]  r_resp_product;
  logic            r_mul_start;
  logic [N-1:0]    r_mul_a;
  logic [N-1:0]    r_mul_b;

  logic [IW-1:0]   w_idx [NREQ];
  logic [NREQ-1:0] w_rot;
  logic [N-1:0]    w_req_a [NREQ];
  logic [N-1:0]    w_req_b [NREQ];
  logic [IW-1:0]   w_pick;
  logic [NREQ-1:0] w_pick_oh;
  logic [NREQ-1:0] w_win_oh;
  logic [IW-1:0]   w_ptr_next;
  logic            w_found;
  logic            w_take;
  logic            w_finish;
  logic            w_timeout;

  // w_rot[k] is the request that sits k places after the pointer, so the
  // lowest set bit of w_rot is the round-robin winner.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_client
      logic [IW:0] w_sum;
      assign w_sum         = {1'b0, r_ptr} + (IW+1)'(gi);
      assign w_idx[gi]     = (w_sum >= (IW+1)'(NREQ)) ? IW'(w_sum - (IW+1)'(NREQ)) : w_sum[IW-1:0];
      assign w_rot[gi]     = req[w_idx[gi]];
      assign w_req_a[gi]   = req_a[gi*N +: N];
      assign w_req_b[gi]   = req_b[gi*N +: N];
      assign w_pick_oh[gi] = (w_pick == IW'(gi));
      assign w_win_oh[gi]  = (r_winner == IW'(gi));
    end
  endgenerate

  always_comb begin
    w_pick = r_ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_pick = w_idx[k];
      end
    end
  end

  assign w_found    = |req;
  assign w_ptr_next = (r_winner == IW'(NREQ - 1)) ? '0 : r_winner + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found && !mul_busy) begin
          w_take       = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (mul_done || w_timeout) begin
          w_finish     = 1'b1;
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // gnt/mul_start and resp_valid are one-cycle pulses: cleared every cycle unless re-armed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr          <= '0;
      r_winner       <= '0;
      r_gnt          <= '0;
      r_resp_valid   <= '0;
      r_resp_product <= '0;
      r_mul_start    <= 1'b0;
      r_mul_a        <= '0;
      r_mul_b        <= '0;
    end else begin
      r_gnt        <= '0;
      r_resp_valid <= '0;
      r_mul_start  <= 1'b0;
      if (w_take) begin
        r_winner    <= w_pick;
        r_gnt       <= w_pick_oh;
        r_mul_start <= 1'b1;
        r_mul_a     <= w_req_a[w_pick];
        r_mul_b     <= w_req_b[w_pick];
      end
      if (w_finish) begin
        r_resp_valid   <= w_win_oh;
        r_resp_product <= w_timeout ? '0 : mul_product;
      end
      if (r_state == S_RESP) begin
        r_ptr <= w_ptr_next;
      end
    end
  end

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_wd_cnt;
  logic          r_resp_err;

  // Counter reads 0 in the first WAIT cycle; abort fires in the TIMEOUT-th WAIT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd_cnt   <= '0;
      r_resp_err <= 1'b0;
    end else begin
      r_wd_cnt   <= (r_state == S_WAIT) ? r_wd_cnt + 1'b1 : '0;
      r_resp_err <= w_finish && w_timeout;
    end
  end

  assign w_timeout = (r_state == S_WAIT) && !mul_done && (r_wd_cnt == CW'(TIMEOUT - 1));
  assign resp_err  = r_resp_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_timeout        = 1'b0;
  assign resp_err         = 1'b0;
`endif

  assign gnt              = r_gnt;
  assign resp_valid       = r_resp_valid;
  assign resp_product     = r_resp_product;
  assign mul_start        = r_mul_start;
  assign mul_multiplicand = r_mul_a;
  assign mul_multiplier   = r_mul_b;

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: behavioural multiplier plus a round-robin reference model.
`timescale 1ns/1ps
module tb_mul_arbiter;
  localparam int N = 32;
  localparam int NREQ = 4;
  localparam int TIMEOUT = 48;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*N-1:0]   req_a = '0;
  logic [NREQ*N-1:0]   req_b = '0;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     resp_valid;
  logic [2*N-1:0]      resp_product;
  logic                resp_err;
  logic                mul_start;
  logic [N-1:0]        mul_multiplicand;
  logic [N-1:0]        mul_multiplier;
  logic [2*N-1:0]      mul_product;
  logic                mul_busy;
  logic                mul_done;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int ptr_m = 0;
  int mul_lat = 3;
  bit hang = 1'b0;
  bit force_busy = 1'b0;

  mul_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .resp_valid(resp_valid), .resp_product(resp_product), .resp_err(resp_err),
    .mul_start(mul_start), .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
    .mul_product(mul_product), .mul_busy(mul_busy), .mul_done(mul_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Behavioural sequential multiplier: done pulses mul_lat+1 cycles after the start cycle.
  logic          busy_m, done_m;
  logic [N-1:0]  a_m, b_m;
  logic [2*N-1:0] prod_m;
  int            cnt_m;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_m <= 1'b0; done_m <= 1'b0; prod_m <= '0; cnt_m <= 0; a_m <= '0; b_m <= '0;
    end else begin
      done_m <= 1'b0;
      if (mul_start && !busy_m) begin
        busy_m <= 1'b1; cnt_m <= mul_lat; a_m <= mul_multiplicand; b_m <= mul_multiplier;
      end else if (busy_m && !hang) begin
        if (cnt_m <= 1) begin
          done_m <= 1'b1; busy_m <= 1'b0;
          prod_m <= {{N{1'b0}}, a_m} * {{N{1'b0}}, b_m};
        end else begin
          cnt_m <= cnt_m - 1;
        end
      end
    end
  end
  assign mul_done    = done_m;
  assign mul_busy    = busy_m | force_busy;
  assign mul_product = done_m ? prod_m : ~prod_m;

  function automatic int rr_pick(input int p, input logic [NREQ-1:0] m);
    for (int k = 0; k < NREQ; k++) begin
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic set_ops(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
  endtask

  task automatic wait_gnt(input int budget, output logic [NREQ-1:0] g, output int at, output bit ok);
    ok = 1'b0; g = '0; at = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (gnt !== '0) begin g = gnt; at = cycle; ok = 1'b1; break; end
    end
  endtask

  task automatic wait_resp(input int budget, output logic [NREQ-1:0] rv, output logic [2*N-1:0] prod,
                           output logic err, output int at, output bit ok, output int extra);
    ok = 1'b0; rv = '0; prod = '0; err = 1'b0; at = 0; extra = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (gnt !== '0 || mul_start !== 1'b0) extra++;
      if (resp_valid !== '0) begin
        rv = resp_valid; prod = resp_product; err = resp_err; at = cycle; ok = 1'b1; break;
      end
    end
  endtask

  task automatic test_reset();
    req = '0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (gnt !== '0) begin bad++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    total++; if (resp_valid !== '0) begin bad++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
    total++; if (mul_start !== 1'b0) begin bad++; $display("FAIL reset_mul_start: got %b want 0", mul_start); end
    total++; if (resp_product !== '0) begin bad++; $display("FAIL reset_product: got %h want 0", resp_product); end
    total++; if ({mul_multiplicand, mul_multiplier} !== '0) begin
      bad++; $display("FAIL reset_operands: got %h/%h want 0/0", mul_multiplicand, mul_multiplier);
    end
    rst = 1'b1;
    ptr_m = 0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [NREQ-1:0] g, rv; logic [2*N-1:0] prod; logic err; int gc, rc, extra; bit ok;
    mul_lat = 3;
    set_ops(2, 32'd7, 32'd6);
    req[2] = 1'b1;
    wait_gnt(20, g, gc, ok);
    total++; if (!ok || g !== 4'b0100) begin bad++; $display("FAIL single_gnt: got %b want 0100", g); end
    total++; if (mul_start !== 1'b1) begin bad++; $display("FAIL single_start: got %b want 1", mul_start); end
    total++; if ({mul_multiplicand, mul_multiplier} !== {32'd7, 32'd6}) begin
      bad++; $display("FAIL single_operands: got %0d/%0d want 7/6", mul_multiplicand, mul_multiplier);
    end
    req[2] = 1'b0;
    wait_resp(30, rv, prod, err, rc, ok, extra);
    total++; if (extra !== 0) begin bad++; $display("FAIL single_pulse: got %0d extra gnt/start cycles want 0", extra); end
    total++; if (!ok || rv !== 4'b0100) begin bad++; $display("FAIL single_resp: got %b want 0100", rv); end
    total++; if (prod !== 64'd42) begin bad++; $display("FAIL single_product: got %0d want 42", prod); end
    total++; if (rc - gc != mul_lat + 2) begin bad++; $display("FAIL single_latency: got %0d want %0d", rc - gc, mul_lat + 2); end
    ptr_m = 3;
    @(negedge clk);
  endtask

  task automatic test_arbitration(input logic [NREQ-1:0] mask, input bit fixed);
    logic [N-1:0] a [NREQ]; logic [N-1:0] b [NREQ];
    logic [NREQ-1:0] pend, g, rv; logic [2*N-1:0] prod, exp_p; logic err;
    int gc, rc, extra, w; bit ok;
    mul_lat = fixed ? 3 : int'($urandom_range(1, 8));
    for (int i = 0; i < NREQ; i++) begin
      a[i] = fixed ? N'(i + 1) : N'($urandom);
      b[i] = fixed ? N'(10) : N'($urandom);
      if (mask[i]) set_ops(i, a[i], b[i]);
    end
    req = mask;
    pend = mask;
    while (pend != '0) begin
      w = rr_pick(ptr_m, pend);
      exp_p = {{N{1'b0}}, a[w]} * {{N{1'b0}}, b[w]};
      wait_gnt(40, g, gc, ok);
      total++; if (!ok || g !== onehot(w)) begin bad++; $display("FAIL arb_gnt: got %b want %b (mask %b)", g, onehot(w), mask); end
      if (!ok) break;
      total++; if (mul_start !== 1'b1) begin bad++; $display("FAIL arb_start: got %b want 1", mul_start); end
      total++; if ({mul_multiplicand, mul_multiplier} !== {a[w], b[w]}) begin
        bad++; $display("FAIL arb_operands: got %h/%h want %h/%h", mul_multiplicand, mul_multiplier, a[w], b[w]);
      end
      req[w] = 1'b0;
      pend[w] = 1'b0;
      wait_resp(40, rv, prod, err, rc, ok, extra);
      total++; if (!ok || rv !== onehot(w)) begin bad++; $display("FAIL arb_resp: got %b want %b", rv, onehot(w)); end
      total++; if (prod !== exp_p) begin bad++; $display("FAIL arb_product: got %h want %h", prod, exp_p); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL arb_err: got %b want 0", err); end
      total++; if (extra !== 0) begin bad++; $display("FAIL arb_pulse: got %0d extra gnt/start cycles want 0", extra); end
      total++; if (rc - gc != mul_lat + 2) begin bad++; $display("FAIL arb_latency: got %0d want %0d", rc - gc, mul_lat + 2); end
      ptr_m = (w + 1) % NREQ;
      @(negedge clk);
      total++; if (resp_valid !== '0 || gnt !== '0 || resp_product !== exp_p) begin
        bad++; $display("FAIL arb_idle_hold: got rv=%b gnt=%b prod=%h want 0/0/%h", resp_valid, gnt, resp_product, exp_p);
      end
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] a3, b3; logic [NREQ-1:0] g, rv; logic [2*N-1:0] prod, exp_p; logic err;
    int gc, rc, extra, w; bit ok;
    mul_lat = 4;
    a3 = $urandom; b3 = $urandom;
    set_ops(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    set_ops(3, a3, b3);
    req = 4'b1001;
    for (int j = 0; j < 4; j++) begin
      w = rr_pick(ptr_m, 4'b1001);
      exp_p = (w == 0) ? 64'hFFFF_FFFE_0000_0001 : {{N{1'b0}}, a3} * {{N{1'b0}}, b3};
      wait_gnt(40, g, gc, ok);
      total++; if (!ok || g !== onehot(w)) begin bad++; $display("FAIL fair_gnt: job %0d got %b want %b", j, g, onehot(w)); end
      if (j == 3) req = '0;
      wait_resp(40, rv, prod, err, rc, ok, extra);
      total++; if (!ok || rv !== onehot(w) || prod !== exp_p) begin
        bad++; $display("FAIL fair_resp: job %0d got %b/%h want %b/%h", j, rv, prod, onehot(w), exp_p);
      end
      ptr_m = (w + 1) % NREQ;
    end
    @(negedge clk);
  endtask

  task automatic test_withdrawal();
    logic [NREQ-1:0] g, rv; logic [2*N-1:0] prod; logic err; int gc, rc, extra; bit ok;
    mul_lat = 8;
    set_ops(0, 32'd5, 32'd5);
    req[0] = 1'b1;
    wait_gnt(20, g, gc, ok);
    total++; if (!ok || g !== 4'b0001) begin bad++; $display("FAIL wd_first_gnt: got %b want 0001", g); end
    req[0] = 1'b0;
    @(negedge clk);
    set_ops(1, 32'd11, 32'd11);
    req[1] = 1'b1;
    @(negedge clk);
    req[1] = 1'b0;
    set_ops(2, 32'd3, 32'd9);
    req[2] = 1'b1;
    wait_resp(30, rv, prod, err, rc, ok, extra);
    total++; if (!ok || rv !== 4'b0001 || prod !== 64'd25) begin bad++; $display("FAIL wd_first_resp: got %b/%0d want 0001/25", rv, prod); end
    ptr_m = 1;
    wait_gnt(10, g, gc, ok);
    total++; if (!ok || g !== 4'b0100) begin bad++; $display("FAIL wd_second_gnt: got %b want 0100", g); end
    total++; if ({mul_multiplicand, mul_multiplier} !== {32'd3, 32'd9}) begin
      bad++; $display("FAIL wd_operands: got %0d/%0d want 3/9", mul_multiplicand, mul_multiplier);
    end
    req[2] = 1'b0;
    wait_resp(30, rv, prod, err, rc, ok, extra);
    total++; if (!ok || rv !== 4'b0100 || prod !== 64'd27) begin bad++; $display("FAIL wd_second_resp: got %b/%0d want 0100/27", rv, prod); end
    ptr_m = 3;
    wait_resp(15, rv, prod, err, rc, ok, extra);
    total++; if (ok) begin bad++; $display("FAIL wd_no_resp: got resp_valid %b want none", rv); end
  endtask

  task automatic test_busy();
    logic [NREQ-1:0] g, rv; logic [2*N-1:0] prod; logic err; int gc, rc, extra; bit ok;
    mul_lat = 2;
    force_busy = 1'b1;
    set_ops(1, 32'h1_0000, 32'h3);
    req[1] = 1'b1;
    wait_gnt(10, g, gc, ok);
    total++; if (ok) begin bad++; $display("FAIL busy_hold: got gnt %b while busy want none", g); end
    force_busy = 1'b0;
    wait_gnt(5, g, gc, ok);
    total++; if (!ok || g !== 4'b0010) begin bad++; $display("FAIL busy_release_gnt: got %b want 0010", g); end
    req[1] = 1'b0;
    wait_resp(20, rv, prod, err, rc, ok, extra);
    total++; if (!ok || rv !== 4'b0010 || prod !== 64'h3_0000) begin bad++; $display("FAIL busy_resp: got %b/%h want 0010/30000", rv, prod); end
    ptr_m = 2;
  endtask

  task automatic test_reset_mid();
    logic [NREQ-1:0] g, rv; logic [2*N-1:0] prod; logic err; int gc, rc, extra; bit ok;
    mul_lat = 10;
    set_ops(0, 32'h1234, 32'h10);
    req[0] = 1'b1;
    wait_gnt(20, g, gc, ok);
    req[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    total++; if ({gnt, resp_valid, resp_err, mul_start} !== '0) begin
      bad++; $display("FAIL midrst_ctrl: got gnt=%b rv=%b err=%b start=%b want 0", gnt, resp_valid, resp_err, mul_start);
    end
    total++; if ({resp_product, mul_multiplicand, mul_multiplier} !== '0) begin
      bad++; $display("FAIL midrst_data: got %h/%h/%h want 0", resp_product, mul_multiplicand, mul_multiplier);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ptr_m = 0;
    wait_resp(20, rv, prod, err, rc, ok, extra);
    total++; if (ok) begin bad++; $display("FAIL midrst_stale: got resp_valid %b want none", rv); end
    mul_lat = 3;
    set_ops(1, 32'd100, 32'd7);
    set_ops(3, 32'd1, 32'd1);
    req = 4'b1010;
    wait_gnt(20, g, gc, ok);
    total++; if (!ok || g !== 4'b0010) begin bad++; $display("FAIL midrst_ptr: got %b want 0010", g); end
    req = '0;
    wait_resp(20, rv, prod, err, rc, ok, extra);
    total++; if (!ok || rv !== 4'b0010 || prod !== 64'd700) begin bad++; $display("FAIL midrst_resp: got %b/%0d want 0010/700", rv, prod); end
    ptr_m = 2;
  endtask

  task automatic test_long_wait();
    logic [NREQ-1:0] g, rv; logic [2*N-1:0] prod; logic err; int gc, rc, extra; bit ok;
    mul_lat = 2;
    hang = 1'b1;
    set_ops(2, 32'd9, 32'd9);
    req[2] = 1'b1;
    wait_gnt(20, g, gc, ok);
    total++; if (!ok || g !== 4'b0100) begin bad++; $display("FAIL lw_gnt: got %b want 0100", g); end
    req[2] = 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
    wait_resp(200, rv, prod, err, rc, ok, extra);
    total++; if (!ok || rv !== 4'b0100 || err !== 1'b1) begin bad++; $display("FAIL to_resp: got %b err=%b want 0100 err=1", rv, err); end
    total++; if (prod !== '0) begin bad++; $display("FAIL to_product: got %h want 0", prod); end
    total++; if (rc - gc != TIMEOUT + 1) begin bad++; $display("FAIL to_latency: got %0d want %0d", rc - gc, TIMEOUT + 1); end
    hang = 1'b0;
    wait_resp(20, rv, prod, err, rc, ok, extra);
    total++; if (ok) begin bad++; $display("FAIL to_late_done: got resp_valid %b want none", rv); end
    total++; if (resp_product !== '0 || resp_err !== 1'b0) begin
      bad++; $display("FAIL to_after: got prod=%h err=%b want 0/0", resp_product, resp_err);
    end
`else
    wait_resp(100, rv, prod, err, rc, ok, extra);
    total++; if (ok) begin bad++; $display("FAIL lw_no_resp: got resp_valid %b want none", rv); end
    hang = 1'b0;
    wait_resp(20, rv, prod, err, rc, ok, extra);
    total++; if (!ok || rv !== 4'b0100 || prod !== 64'd81 || err !== 1'b0) begin
      bad++; $display("FAIL lw_resp: got %b/%0d err=%b want 0100/81 err=0", rv, prod, err);
    end
`endif
    ptr_m = 3;
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset();
    test_arbitration(4'b1111, 1'b1);
    test_fairness();
    test_withdrawal();
    test_busy();
    test_reset_mid();
    for (int r = 0; r < 12; r++) begin
      test_arbitration(NREQ'($urandom_range(1, 15)), 1'b0);
    end
    test_long_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_timeout: got no completion want finish");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Round-robin arbiter and sequencer that shares one `seq_multiplier` instance between `NREQ` requesters. It accepts operand pairs from requesting clients and issues one multiplication at a time. It returns the 2N-bit product to the granted client with a one-cycle valid pulse. It sits between client blocks and the multiplier's `start`/`busy`/`done` interface.

## Interface
- `N`, 32, operand width; must match the multiplier's `N`.
- `NREQ`, 4, number of requesters, range 2..8.
- `TIMEOUT`, 48, watchdog limit in cycles. Used only with `MUL_ARB_TIMEOUT_EN`.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req` in NREQ: per-client request level.
- `req_a` in NREQ*N: client i multiplicand at bits [i*N +: N].
- `req_b` in NREQ*N: client i multiplier at bits [i*N +: N].
- `gnt` out NREQ: one-hot, one-cycle pulse marking the cycle the operands are latched.
- `resp_valid` out NREQ: one-hot, one-cycle pulse; `resp_product` is valid in that cycle.
- `resp_product` out 2N: last product; holds its value between responses.
- `resp_err` out 1: pulses together with `resp_valid` on a timeout abort. Tied to 0 when the timeout feature is compiled out.
- `mul_start` out 1: one-cycle start pulse to the multiplier.
- `mul_multiplicand` out N: registered operand to the multiplier.
- `mul_multiplier` out N: registered operand to the multiplier.
- `mul_product` in 2N: multiplier result; valid while `mul_done` is high.
- `mul_busy` in 1: multiplier busy level.
- `mul_done` in 1: multiplier completion pulse.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE → ISSUE when `req` is nonzero and `mul_busy` is 0.
  - Winner = first set `req` bit searching upward from `ptr`, wrapping modulo NREQ.
  - On that edge: latch the winner's operands into the `mul_*` operand registers, record the winner index, and register `gnt[winner]` = 1.
- ISSUE: `gnt` is high for this cycle and `mul_start` = 1. Unconditional transition to WAIT.
- WAIT: on `mul_done` = 1, capture `mul_product` into `resp_product` and go to RESP.
- RESP: `resp_valid[winner]` = 1, `ptr` ← (winner+1) mod NREQ, go to IDLE.
- Client rules:
  - A client holds `req` and its operands stable until it sees `gnt`.
  - Dropping `req` before `gnt` withdraws the request; no response is produced.
  - After `gnt`, the client's operands and `req` are don't-care.
  - A client re-raising `req` in the RESP cycle is eligible in the next IDLE.
- `mul_done` outside WAIT is ignored. `mul_busy` is sampled only in IDLE.
- Products are unsigned 2N-bit results passed through unchanged; the arbiter does no arithmetic.
- Reset (async, at any time, including mid-multiply):
  - state = IDLE; `ptr` = 0.
  - `gnt`, `resp_valid`, `resp_err`, `mul_start` = 0.
  - `resp_product`, `mul_multiplicand`, `mul_multiplier` = 0.
  - The in-flight job is dropped; no response is emitted.

## Timing
- Request sampled in IDLE at edge k: `gnt` and `mul_start` are high during cycle k+1.
- `mul_done` high in cycle d: `resp_valid` high in cycle d+1.
- Total latency = multiplier latency + 3 cycles.
- Back-to-back: the next grant can be issued at edge d+2 at the earliest, i.e. there is at least one IDLE cycle between jobs.
- Simultaneous requests: exactly one grant per job; round-robin from `ptr`. With all clients requesting continuously, every client is served within NREQ jobs.

## Configuration
- Macro `MUL_ARB_TIMEOUT_EN`.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches `TIMEOUT` without `mul_done`, go to RESP with `resp_product` = 0 and `resp_err` = 1 alongside `resp_valid`.
  - `ptr` advances normally.
  - A late `mul_done` is ignored.
- Not defined: no counter; WAIT lasts indefinitely; `resp_err` is constant 0.

## Test plan
- Single request: client 2 requests with a=7, b=6 → `gnt` = 4'b0100 for 1 cycle, one `mul_start` pulse, then `resp_valid` = 4'b0100 with `resp_product` = 42.
- Simultaneous requests: all four clients request after reset with a=i+1, b=10 → grant order 0,1,2,3; products 10, 20, 30, 40, each returned to the correct client.
- Fairness: clients 0 and 3 hold `req` continuously → grants alternate 0,3,0,3. Full-width check: 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE00000001.
- Withdrawal: client 1 drops `req` in the same cycle client 2 raises it while a job is in WAIT → the next grant goes to client 2; client 1 never gets `resp_valid`.
- Reset mid-operation: assert `rst` low during WAIT → all outputs 0 immediately; after release, `ptr` = 0, no stale `resp_valid`, and the next request is served normally.
- Timeout (`MUL_ARB_TIMEOUT_EN`, TIMEOUT=48): `mul_done` held low → `resp_valid` and `resp_err` pulse 48 cycles after entering WAIT, `resp_product` = 0. A late `mul_done` produces no extra response.
